// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared constants for the load/store unit and the data memory.
//               Holds the RV32I funct3 width codes, the RAM window and the ROM
//               word addresses, the FSM state type and lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] RAM_SIZE  = 32'h0000_1000;
  localparam logic [31:0] ROM_WORD0 = 32'h0010_0000;
  localparam logic [31:0] ROM_WORD1 = 32'h0010_0004;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsuState_t;

  // size is funct3[1:0]: 00 byte, 01 half, otherwise word
  function automatic logic [3:0] byteSelect(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-aligned store data is copied to every lane so the byte selects
  // alone decide which bytes land in memory.
  function automatic logic [31:0] laneReplicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Core-side request/response bundle of the load/store unit.
//               master : core (drives req*, receives reqReady and resp*)
//               slave  : load/store unit
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respMisaligned;
  logic        respFault;

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqWdata,
    input  reqReady, respValid, respRdata, respMisaligned, respFault
  );

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqWdata,
    output reqReady, respValid, respRdata, respMisaligned, respFault
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational lane extraction and sign/zero extension of a
//               loaded memory word.
//   memData  : full 32-bit word returned by the memory
//   offset   : byte offset of the access (addr[1:0])
//   funct3   : load width code
//   loadData : right-aligned, extended load result (0 for unknown codes)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] memData,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] loadData
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = memData >> {offset, 3'b000};
    loadData  = 32'h0;
    case (funct3)
      F3_LB:   loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   loadData = memData;
      F3_LBU:  loadData = {24'h0, w_shifted[7:0]};
      F3_LHU:  loadData = {16'h0, w_shifted[15:0]};
      default: loadData = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit. Accepts one request at a time, checks
//               alignment and address map, issues a single memory access and
//               returns a one-cycle response.
//   clk, rst           : clock, synchronous active-high reset
//   lsu (slave)        : core request/response bundle
//   memReadEnable ...  : memory-side controls, non-zero only in ISSUE
//   memDataOut         : memory read data, valid one edge after memReadEnable
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  lsu,
  output logic              memReadEnable,
  output logic              memWriteEnable,
  output logic [3:0]        memReadByteSelect,
  output logic [3:0]        memWriteByteSelect,
  output logic [2:0]        memLoadSelect,
  output logic [31:0]       memAddress,
  output logic [31:0]       memDataIn,
  input  logic [31:0]       memDataOut
);

  lsuState_t   r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addrLow;
  logic        r_reqReady;
  logic        r_respValid;
  logic [31:0] r_respRdata;
  logic        r_respMisaligned;
  logic        r_respFault;
  logic        r_memRe;
  logic        r_memWe;
  logic [3:0]  r_memRsel;
  logic [3:0]  r_memWsel;
  logic [2:0]  r_memLoadSel;
  logic [31:0] r_memAddr;
  logic [31:0] r_memDin;

  logic        w_accept;
  logic        w_legal;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_inRam;
  logic        w_isRom;
  logic        w_fault;
  logic [3:0]  w_sel;
  logic [31:0] w_loadData;

  // Request checks operate on the live request so the accept edge already
  // knows whether to issue or to go straight to the response.
  always_comb begin
    w_accept = lsu.reqValid && r_reqReady;
    w_size   = lsu.reqFunct3[1:0];
    if (lsu.reqWrite)
      w_legal = (lsu.reqFunct3 == F3_SB) || (lsu.reqFunct3 == F3_SH) || (lsu.reqFunct3 == F3_SW);
    else
      w_legal = (lsu.reqFunct3 == F3_LB) || (lsu.reqFunct3 == F3_LH) || (lsu.reqFunct3 == F3_LW) ||
                (lsu.reqFunct3 == F3_LBU) || (lsu.reqFunct3 == F3_LHU);
    w_misaligned = w_legal && (((w_size == 2'b01) && lsu.reqAddr[0]) ||
                               ((w_size == 2'b10) && (lsu.reqAddr[1:0] != 2'b00)));
    // Unsigned wrap makes addresses below RAM_BASE land far above RAM_SIZE.
    w_inRam = (lsu.reqAddr - RAM_BASE) < RAM_SIZE;
    w_isRom = (lsu.reqAddr == ROM_WORD0) || (lsu.reqAddr == ROM_WORD1);
    w_fault = !w_legal || !(w_inRam || w_isRom) ||
              (w_isRom && (lsu.reqWrite || (lsu.reqFunct3 != F3_LW)));
    w_sel   = byteSelect(w_size, lsu.reqAddr[1:0]);
  end

  lsu_load_align u_align (
    .memData  (memDataOut),
    .offset   (r_addrLow),
    .funct3   (r_funct3),
    .loadData (w_loadData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_write          <= 1'b0;
      r_funct3         <= 3'b000;
      r_addrLow        <= 2'b00;
      r_reqReady       <= 1'b1;
      r_respValid      <= 1'b0;
      r_respRdata      <= 32'h0;
      r_respMisaligned <= 1'b0;
      r_respFault      <= 1'b0;
      r_memRe          <= 1'b0;
      r_memWe          <= 1'b0;
      r_memRsel        <= 4'h0;
      r_memWsel        <= 4'h0;
      r_memLoadSel     <= 3'b000;
      r_memAddr        <= 32'h0;
      r_memDin         <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write    <= lsu.reqWrite;
            r_funct3   <= lsu.reqFunct3;
            r_addrLow  <= lsu.reqAddr[1:0];
            r_reqReady <= 1'b0;
            if (w_misaligned || w_fault) begin
              r_state          <= RESP;
              r_respValid      <= 1'b1;
              r_respRdata      <= 32'h0;
              r_respMisaligned <= w_misaligned;
              r_respFault      <= !w_misaligned;
            end else begin
              // Memory controls are loaded here so they are live for
              // exactly the ISSUE cycle.
              r_state      <= ISSUE;
              r_memRe      <= !lsu.reqWrite;
              r_memWe      <= lsu.reqWrite;
              r_memRsel    <= lsu.reqWrite ? 4'h0 : w_sel;
              r_memWsel    <= lsu.reqWrite ? w_sel : 4'h0;
              r_memLoadSel <= lsu.reqFunct3;
              r_memAddr    <= lsu.reqAddr;
              r_memDin     <= lsu.reqWrite ? laneReplicate(w_size, lsu.reqWdata) : 32'h0;
            end
          end
        end
        ISSUE: begin
          r_memRe      <= 1'b0;
          r_memWe      <= 1'b0;
          r_memRsel    <= 4'h0;
          r_memWsel    <= 4'h0;
          r_memLoadSel <= 3'b000;
          r_memAddr    <= 32'h0;
          r_memDin     <= 32'h0;
          if (r_write) begin
            r_state          <= RESP;
            r_respValid      <= 1'b1;
            r_respRdata      <= 32'h0;
            r_respMisaligned <= 1'b0;
            r_respFault      <= 1'b0;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_state          <= RESP;
          r_respValid      <= 1'b1;
          r_respRdata      <= w_loadData;
          r_respMisaligned <= 1'b0;
          r_respFault      <= 1'b0;
        end
        RESP: begin
          r_state          <= IDLE;
          r_reqReady       <= 1'b1;
          r_respValid      <= 1'b0;
          r_respRdata      <= 32'h0;
          r_respMisaligned <= 1'b0;
          r_respFault      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu.reqReady       = r_reqReady;
  assign lsu.respValid      = r_respValid;
  assign lsu.respRdata      = r_respRdata;
  assign lsu.respMisaligned = r_respMisaligned;
  assign lsu.respFault      = r_respFault;

  assign memReadEnable      = r_memRe;
  assign memWriteEnable     = r_memWe;
  assign memReadByteSelect  = r_memRsel;
  assign memWriteByteSelect = r_memWsel;
  assign memLoadSelect      = r_memLoadSel;
  assign memAddress         = r_memAddr;
  assign memDataIn          = r_memDin;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a behavioural
//               data memory, a vector table and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if lsu ();

  logic        memReadEnable, memWriteEnable;
  logic [3:0]  memReadByteSelect, memWriteByteSelect;
  logic [2:0]  memLoadSelect;
  logic [31:0] memAddress, memDataIn, memDataOut;

  load_store_unit dut (
    .clk                (clk),
    .rst                (rst),
    .lsu                (lsu),
    .memReadEnable      (memReadEnable),
    .memWriteEnable     (memWriteEnable),
    .memReadByteSelect  (memReadByteSelect),
    .memWriteByteSelect (memWriteByteSelect),
    .memLoadSelect      (memLoadSelect),
    .memAddress         (memAddress),
    .memDataIn          (memDataIn),
    .memDataOut         (memDataOut)
  );

  // Behavioural data memory: 4 KiB RAM plus two ROM words, registered read.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      memDataOut <= 32'h0;
    end else begin
      if (memWriteEnable && (memAddress[31:12] == 20'h80000))
        for (int b = 0; b < 4; b++)
          if (memWriteByteSelect[b]) ram[memAddress[11:2]][8*b +: 8] <= memDataIn[8*b +: 8];
      if (memReadEnable) begin
        if (memAddress[31:2] == 30'h0004_0000)      memDataOut <= 32'h009D_C264;
        else if (memAddress[31:2] == 30'h0004_0001) memDataOut <= 32'h1234_5678;
        else                                        memDataOut <= ram[memAddress[11:2]];
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          due;
  } sb_t;
  sb_t sb[$];

  int          reCount = 0, weCount = 0;
  logic [3:0]  lastRsel, lastWsel;
  logic [2:0]  lastLoadSel;
  logic [31:0] lastDin;

  // Monitor: memory activity snoop and response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (memReadEnable) begin
        reCount++;
        lastRsel    = memReadByteSelect;
        lastLoadSel = memLoadSelect;
      end
      if (memWriteEnable) begin
        weCount++;
        lastWsel = memWriteByteSelect;
        lastDin  = memDataIn;
      end
      if (!memReadEnable && !memWriteEnable)
        chk("mem_idle_zero", {memReadByteSelect, memWriteByteSelect, 21'h0, memLoadSelect} |
            memAddress | memDataIn, 32'h0);
      if (memReadEnable && memWriteEnable) chk("mem_enable_mutex", 32'h1, 32'h0);
      if (lsu.respValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("resp_rdata", lsu.respRdata, e.rdata);
          chk("resp_misaligned", {31'h0, lsu.respMisaligned}, {31'h0, e.mis});
          chk("resp_fault", {31'h0, lsu.respFault}, {31'h0, e.fault});
          chk("resp_latency_cycle", cyc, e.due);
        end
      end
    end
  end

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expMis;
    logic        expFault;
    logic [3:0]  expSel;
    logic [31:0] expDin;
  } vec_t;

  function automatic vec_t mk(logic w, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic m, logic fl, logic [3:0] s, logic [31:0] d);
    vec_t v;
    v.write = w; v.f3 = f; v.addr = a; v.wdata = wd; v.expRdata = rd;
    v.expMis = m; v.expFault = fl; v.expSel = s; v.expDin = d;
    return v;
  endfunction

  function automatic int latOf(vec_t v);
    if (v.expMis || v.expFault) return 1;
    return v.write ? 2 : 3;
  endfunction

  function automatic sb_t expOf(vec_t v, int acceptCyc);
    sb_t e;
    e.rdata = v.expRdata; e.mis = v.expMis; e.fault = v.expFault;
    e.due = acceptCyc + latOf(v) - 1;
    return e;
  endfunction

  task automatic drive(vec_t v);
    lsu.reqValid  = 1'b1;
    lsu.reqWrite  = v.write;
    lsu.reqFunct3 = v.f3;
    lsu.reqAddr   = v.addr;
    lsu.reqWdata  = v.wdata;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_resp_timeout"}, 32'h1, 32'h0);
      sb.delete();
    end
  endtask

  task automatic doReq(vec_t v);
    int n = 0;
    int re0, we0;
    @(negedge clk);
    while (!lsu.reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'h0, lsu.reqReady}, 32'h1);
    re0 = reCount;
    we0 = weCount;
    drive(v);
    @(posedge clk);
    #1;
    sb.push_back(expOf(v, cyc));
    lsu.reqValid = 1'b0;
    drain("vec");
    repeat (1) @(posedge clk);
    if (latOf(v) == 1) begin
      chk("err_no_read", reCount - re0, 0);
      chk("err_no_write", weCount - we0, 0);
    end else if (v.write) begin
      chk("store_write_pulses", weCount - we0, 1);
      chk("store_no_read", reCount - re0, 0);
      chk("store_write_sel", {28'h0, lastWsel}, {28'h0, v.expSel});
      chk("store_data_in", lastDin, v.expDin);
    end else begin
      chk("load_read_pulses", reCount - re0, 1);
      chk("load_no_write", weCount - we0, 0);
      chk("load_read_sel", {28'h0, lastRsel}, {28'h0, v.expSel});
      chk("load_select", {29'h0, lastLoadSel}, {29'h0, v.f3});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t b2b[$];
    int idx, n;
    logic rdy;

    rst = 1'b1;
    lsu.reqValid = 1'b0; lsu.reqWrite = 1'b0; lsu.reqFunct3 = 3'b0;
    lsu.reqAddr = 32'h0; lsu.reqWdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_reqReady", {31'h0, lsu.reqReady}, 32'h1);
    chk("reset_respValid", {31'h0, lsu.respValid}, 32'h0);
    chk("reset_respRdata", lsu.respRdata, 32'h0);
    chk("reset_flags", {30'h0, lsu.respMisaligned, lsu.respFault}, 32'h0);
    chk("reset_mem_enables", {30'h0, memReadEnable, memWriteEnable}, 32'h0);

    //             wr   f3      addr          wdata         rdata         mis  flt  sel      din
    vecs.push_back(mk(1, 3'b010, 32'h8000_0010, 32'hCAFE_BABE, 32'h0,        0, 0, 4'b1111, 32'hCAFE_BABE));
    vecs.push_back(mk(0, 3'b010, 32'h8000_0010, 32'h0,        32'hCAFE_BABE, 0, 0, 4'b1111, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h8000_0013, 32'h0000_00F0, 32'h0,        0, 0, 4'b1000, 32'hF0F0_F0F0));
    vecs.push_back(mk(0, 3'b000, 32'h8000_0013, 32'h0,        32'hFFFF_FFF0, 0, 0, 4'b1000, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'h8000_0013, 32'h0,        32'h0000_00F0, 0, 0, 4'b1000, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h0010_0000, 32'h0,        32'h009D_C264, 0, 0, 4'b1111, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h0010_0004, 32'h1111_1111, 32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h9000_0000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h8000_0022, 32'h1234_ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD));
    vecs.push_back(mk(0, 3'b001, 32'h8000_0022, 32'h0,        32'hFFFF_ABCD, 0, 0, 4'b1100, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h8000_0022, 32'h0,        32'h0000_ABCD, 0, 0, 4'b1100, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h8000_1000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h0010_0000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h8000_0002, 32'h5555_5555, 32'h0,        1, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h0010_0001, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h8000_0000, 32'h0000_0077, 32'h0,        0, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h8000_0FFF, 32'h0,        32'h0,        0, 0, 4'b1000, 32'h0));

    for (int i = 0; i < vecs.size(); i++) doReq(vecs[i]);

    // Back-to-back with reqValid held high; word at 0x80000010 is now F0FEBABE.
    b2b.push_back(mk(0, 3'b010, 32'h8000_0010, 32'h0, 32'hF0FE_BABE, 0, 0, 4'b1111, 32'h0));
    b2b.push_back(mk(0, 3'b001, 32'h8000_0012, 32'h0, 32'hFFFF_F0FE, 0, 0, 4'b1100, 32'h0));
    b2b.push_back(mk(0, 3'b010, 32'h9000_0000, 32'h0, 32'h0,         0, 1, 4'b0000, 32'h0));
    b2b.push_back(mk(1, 3'b010, 32'h8000_0011, 32'h0, 32'h0,         1, 0, 4'b0000, 32'h0));
    idx = 0;
    n = 0;
    while (idx < b2b.size() && n < 60) begin
      @(negedge clk);
      drive(b2b[idx]);
      rdy = lsu.reqReady;
      @(posedge clk);
      #1;
      n++;
      if (rdy) begin
        sb.push_back(expOf(b2b[idx], cyc));
        idx++;
      end
    end
    lsu.reqValid = 1'b0;
    chk("b2b_accept_count", idx, b2b.size());
    drain("b2b");

    // Reset while a load sits in CAPTURE.
    @(negedge clk);
    drive(mk(0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 0, 0, 4'b1111, 32'h0));
    @(posedge clk);
    #1;
    lsu.reqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_capture_no_resp", {31'h0, lsu.respValid}, 32'h0);
    chk("rst_capture_ready", {31'h0, lsu.reqReady}, 32'h1);
    chk("rst_capture_no_mem", {30'h0, memReadEnable, memWriteEnable}, 32'h0);
    repeat (4) @(posedge clk);
    doReq(mk(0, 3'b010, 32'h0010_0000, 32'h0, 32'h009D_C264, 0, 0, 4'b1111, 32'h0));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
